// File: rtl/game_sequencer.sv
// Game controller: button conditioning, game-state FSM, level/step timing,
// high score and play-time bookkeeping for the rock/bullet/blaster datapath.
module game_sequencer #(
    parameter int DEBOUNCE_MS  = 20,
    parameter int LEVEL_STEP   = 10,
    parameter int MAX_LEVEL    = 7,
    parameter int BASE_PERIOD  = 8,
    parameter int OVER_HOLD_MS = 3000
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [5:0] game_over_in,
    input  logic [5:0] score_in,
    output logic [1:0] game_state,
    output logic       datapath_reset_n,
    output logic [2:0] level,
    output logic       step_tick,
    output logic [5:0] high_score,
    output logic [9:0] play_seconds
);
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = $clog2(OVER_HOLD_MS + 1);
    localparam int SW = $clog2(BASE_PERIOD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        OVER  = 2'b10,
        PAUSE = 2'b11
    } state_t;

    // bit 0 = start, bit 1 = pause
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync2_q, deb_q, press_q;
    logic [DW-1:0] dcnt_q [2];

    assign btn_raw = {pause_btn, start_btn};

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int b = 0; b < 2; b++) dcnt_q[b] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int b = 0; b < 2; b++) begin
                press_q[b] <= 1'b0;
                if (sync2_q[b] == deb_q[b]) begin
                    dcnt_q[b] <= '0;
                end else if (dcnt_q[b] == DW'(DEBOUNCE_MS - 1)) begin
                    dcnt_q[b]  <= '0;
                    deb_q[b]   <= sync2_q[b];
                    press_q[b] <= sync2_q[b];
                end else begin
                    dcnt_q[b] <= dcnt_q[b] + DW'(1);
                end
            end
        end
    end

    state_t        state_q, state_d;
    logic [2:0]    level_q, level_d;
    logic [SW-1:0] step_q, step_d;
    logic          tick_q, tick_d;
    logic [9:0]    ms_q, ms_d;
    logic [9:0]    secs_q, secs_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [5:0]    hs_q, hs_d;
    logic          dprst_q, dprst_d;

    logic          game_start, hold_done, play_run, over_entry;
    logic [5:0]    lvl_raw;
    logic [2:0]    lvl_new;
    logic [SW-1:0] period;

    assign hold_done = (hold_q == HW'(OVER_HOLD_MS));

    always_comb begin
        state_d    = state_q;
        game_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press_q[0]) begin
                    state_d    = PLAY;
                    game_start = 1'b1;
                end
            end
            PLAY: begin
                if (game_over_in != '0) state_d = OVER;
                else if (press_q[1])    state_d = PAUSE;
            end
            PAUSE: begin
                if (press_q[1]) state_d = PLAY;
            end
            OVER: begin
                if (press_q[0] && hold_done) begin
                    state_d    = PLAY;
                    game_start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // counters only advance on cycles that stay in PLAY, so step_tick never
    // fires while game_state shows anything else
    assign play_run   = (state_q == PLAY) && (state_d == PLAY);
    assign over_entry = (state_q == PLAY) && (state_d == OVER);
    assign lvl_raw    = score_in / 6'(LEVEL_STEP);
    assign lvl_new    = (lvl_raw > 6'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : lvl_raw[2:0];
    assign period     = (int'(level_q) < BASE_PERIOD - 1)
                      ? SW'(BASE_PERIOD - int'(level_q)) : SW'(1);

    always_comb begin
        level_d = level_q;
        step_d  = step_q;
        tick_d  = 1'b0;
        ms_d    = ms_q;
        secs_d  = secs_q;
        hold_d  = hold_q;
        hs_d    = hs_q;
        dprst_d = 1'b1;
        if (state_q == PLAY) level_d = lvl_new;
        if (play_run) begin
            // >= absorbs a period that shrank below the running count
            if (step_q >= period - SW'(1)) begin
                step_d = '0;
                tick_d = 1'b1;
            end else begin
                step_d = step_q + SW'(1);
            end
            if (ms_q == 10'd999) begin
                ms_d = '0;
                if (secs_q != '1) secs_d = secs_q + 10'd1;
            end else begin
                ms_d = ms_q + 10'd1;
            end
        end
        if (state_q == OVER && !hold_done) hold_d = hold_q + HW'(1);
        if (over_entry) begin
            hold_d = '0;
            if (score_in > hs_q) hs_d = score_in;
        end
        if (game_start) begin
            dprst_d = 1'b0;
            level_d = '0;
            step_d  = '0;
            tick_d  = 1'b0;
            ms_d    = '0;
            secs_d  = '0;
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            state_q <= IDLE;
            level_q <= '0;
            step_q  <= '0;
            tick_q  <= 1'b0;
            ms_q    <= '0;
            secs_q  <= '0;
            hold_q  <= '0;
            hs_q    <= '0;
            dprst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            secs_q  <= secs_d;
            hold_q  <= hold_d;
            hs_q    <= hs_d;
            dprst_q <= dprst_d;
        end
    end

    assign game_state       = state_q;
    assign datapath_reset_n = dprst_q;
    assign level            = level_q;
    assign step_tick        = tick_q;
    assign high_score       = hs_q;
    assign play_seconds     = secs_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a behavioural model predicts every
// cycle's outputs, a monitor compares them; directed checks cover key points.
module tb_game_sequencer;
    localparam int DEB   = 20;
    localparam int LSTEP = 10;
    localparam int MAXL  = 7;
    localparam int BASE  = 8;
    localparam int HOLD  = 3000;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER  = 3;

    logic       clk_1ms = 1'b0;
    logic       reset;
    logic       start_btn, pause_btn;
    logic [5:0] game_over_in, score_in;
    logic [1:0] game_state;
    logic       datapath_reset_n;
    logic [2:0] level;
    logic       step_tick;
    logic [5:0] high_score;
    logic [9:0] play_seconds;

    always #5 clk_1ms = ~clk_1ms;

    game_sequencer dut (
        .clk_1ms          (clk_1ms),
        .reset            (reset),
        .start_btn        (start_btn),
        .pause_btn        (pause_btn),
        .game_over_in     (game_over_in),
        .score_in         (score_in),
        .game_state       (game_state),
        .datapath_reset_n (datapath_reset_n),
        .level            (level),
        .step_tick        (step_tick),
        .high_score       (high_score),
        .play_seconds     (play_seconds)
    );

    typedef struct packed {
        logic [1:0] gs;
        logic       dp;
        logic [2:0] lv;
        logic       tk;
        logic [5:0] hs;
        logic [9:0] ps;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // model state
    int          mode, lvl, hs, play_ms, since, over_age;
    bit          dp, tick;
    logic [1:0]  rd   [2];
    logic [31:0] sh   [2];
    int          nval [2];
    bit          deb  [2];
    bit          pend [2];

    function automatic logic [1:0] bus_code(int m);
        case (m)
            M_PLAY:  return 2'b01;
            M_PAUSE: return 2'b11;
            M_OVER:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_step();
        int   nxt, per, sc, secs;
        bit   go_start, ps, pp, run;
        logic raw [2];
        logic sv;
        logic [31:0] mask;
        exp_t e;
        mask   = (32'd1 << DEB) - 32'd1;
        raw[0] = start_btn;
        raw[1] = pause_btn;
        sc     = int'(score_in);
        if (!reset) begin
            mode = M_IDLE; lvl = 0; hs = 0; play_ms = 0;
            since = 0; over_age = 0; dp = 0; tick = 0;
            for (int b = 0; b < 2; b++) begin
                rd[b] = '0; sh[b] = '0; nval[b] = 0;
                deb[b] = 0; pend[b] = 0;
            end
        end else begin
            ps = pend[0];
            pp = pend[1];
            // button seen two edges late; level accepted once the last DEB
            // synchronised samples all disagree with it
            for (int b = 0; b < 2; b++) begin
                sv    = rd[b][1];
                rd[b] = {rd[b][0], raw[b]};
                sh[b] = {sh[b][30:0], sv};
                if (nval[b] < 32) nval[b]++;
                pend[b] = 0;
                if (nval[b] >= DEB &&
                    (sh[b] & mask) == (deb[b] ? 32'd0 : mask)) begin
                    deb[b]  = sv;
                    pend[b] = sv;
                end
            end
            per      = (BASE - lvl > 1) ? BASE - lvl : 1;
            nxt      = mode;
            go_start = 0;
            case (mode)
                M_IDLE:  go_start = ps;
                M_PLAY:  if (game_over_in != 0) nxt = M_OVER;
                         else if (pp) nxt = M_PAUSE;
                M_PAUSE: if (pp) nxt = M_PLAY;
                default: go_start = ps && (over_age >= HOLD);
            endcase
            if (go_start) nxt = M_PLAY;
            if (mode == M_PLAY) lvl = (sc / LSTEP > MAXL) ? MAXL : sc / LSTEP;
            run  = (mode == M_PLAY) && (nxt == M_PLAY);
            tick = 0;
            if (run) begin
                play_ms++;
                since++;
                if (since >= per) begin
                    tick  = 1;
                    since = 0;
                end
            end
            if (mode == M_OVER && over_age < HOLD) over_age++;
            if (mode == M_PLAY && nxt == M_OVER) begin
                over_age = 0;
                if (sc > hs) hs = sc;
            end
            dp = !go_start;
            if (go_start) begin
                lvl = 0; tick = 0; since = 0; play_ms = 0;
            end
            mode = nxt;
        end
        secs = play_ms / 1000;
        if (secs > 1023) secs = 1023;
        e.gs = bus_code(mode);
        e.dp = dp;
        e.lv = 3'(lvl);
        e.tk = tick;
        e.hs = 6'(hs);
        e.ps = 10'(secs);
        expq.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk_1ms);
            model_step();
        end
    end

    // monitor: one scoreboard entry per clock edge
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clk_1ms);
            #1;
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e   = expq.pop_front();
                got = {game_state, datapath_reset_n, level, step_tick,
                       high_score, play_seconds};
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs at %0t: got gs=%b dp=%b lv=%0d tk=%b hs=%0d ps=%0d, expected gs=%b dp=%b lv=%0d tk=%b hs=%0d ps=%0d",
                             $time, got.gs, got.dp, got.lv, got.tk, got.hs, got.ps,
                             e.gs, e.dp, e.lv, e.tk, e.hs, e.ps);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk_1ms);
    endtask

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic count_ticks(int n, output int t);
        t = 0;
        repeat (n) begin
            @(posedge clk_1ms);
            #1;
            t += int'(step_tick);
        end
    endtask

    task automatic wait_state(logic [1:0] code, int maxc, output int n);
        n = 0;
        do begin
            @(posedge clk_1ms);
            #1;
            n++;
        end while (game_state !== code && n < maxc);
    endtask

    initial begin
        int n, t;
        reset        = 1'b0;
        start_btn    = 1'b0;
        pause_btn    = 1'b0;
        game_over_in = '0;
        score_in     = '0;
        cyc(3);
        chk("reset_state", int'(game_state), 0);
        chk("reset_dp", int'(datapath_reset_n), 0);
        reset = 1'b1;
        cyc(2);

        for (int i = 0; i < 20; i++) begin
            start_btn = ~start_btn;
            cyc(5);
        end
        for (int i = 0; i < 10; i++) begin
            start_btn = ~start_btn;
            cyc($urandom_range(1, DEB - 1));
        end
        start_btn = 1'b0;
        cyc(30);
        chk("bounce_idle", int'(game_state), 0);

        start_btn = 1'b1;
        wait_state(2'b01, 60, n);
        chk("start_latency", n, 23);
        chk("start_dp_low", int'(datapath_reset_n), 0);
        @(negedge clk_1ms);
        cyc(6);
        start_btn = 1'b0;

        count_ticks(80, t);
        chk("ticks_lvl0", t, 10);
        @(negedge clk_1ms);
        score_in = 6'd25;
        cyc(10);
        count_ticks(60, t);
        chk("ticks_lvl2", t, 10);
        chk("level_25", int'(level), 2);
        @(negedge clk_1ms);
        score_in = 6'd63;
        cyc(10);
        count_ticks(60, t);
        chk("ticks_lvl6", t, 30);
        chk("level_63", int'(level), 6);
        @(negedge clk_1ms);
        for (int i = 0; i < 100; i++) begin
            score_in = 6'($urandom_range(0, 63));
            cyc(1);
        end

        score_in = '0;
        cyc(2500);
        pause_btn = 1'b1;
        cyc(30);
        pause_btn = 1'b0;
        chk("paused", int'(game_state), 3);
        chk("pause_secs", int'(play_seconds), 2);
        count_ticks(1000, t);
        chk("pause_silent", t, 0);
        @(negedge clk_1ms);
        pause_btn = 1'b1;
        cyc(30);
        pause_btn = 1'b0;
        chk("resumed", int'(game_state), 1);

        score_in = 6'd5;
        cyc(5);
        game_over_in = 6'd1;
        cyc(1);
        game_over_in = '0;
        chk("over_1", int'(game_state), 2);
        chk("hs_5", int'(high_score), 5);
        cyc(3100);
        start_btn = 1'b1;
        wait_state(2'b01, 60, n);
        chk("restart_latency", n, 23);
        @(negedge clk_1ms);
        cyc(6);
        start_btn = 1'b0;
        score_in  = 6'd12;
        cyc(5);

        pause_btn = 1'b1;
        cyc(22);
        game_over_in = 6'h0F;
        cyc(1);
        chk("over_priority", int'(game_state), 2);
        chk("hs_12", int'(high_score), 12);
        cyc(3);
        game_over_in = '0;
        cyc(4);
        pause_btn = 1'b0;
        cyc(1000);
        start_btn = 1'b1;
        cyc(30);
        start_btn = 1'b0;
        chk("early_start_ignored", int'(game_state), 2);
        cyc(2100);
        start_btn = 1'b1;
        wait_state(2'b01, 60, n);
        chk("late_start", int'(game_state), 1);
        chk("late_start_level", int'(level), 0);
        chk("late_start_secs", int'(play_seconds), 0);
        @(negedge clk_1ms);
        cyc(6);
        start_btn = 1'b0;

        pause_btn = 1'b1;
        cyc(30);
        pause_btn = 1'b0;
        chk("pause_before_reset", int'(game_state), 3);
        cyc(30);
        reset = 1'b0;
        cyc(1);
        chk("midreset_state", int'(game_state), 0);
        chk("midreset_hs", int'(high_score), 0);
        chk("midreset_dp", int'(datapath_reset_n), 0);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("release_dp", int'(datapath_reset_n), 1);

        start_btn = 1'b1;
        cyc(30);
        start_btn = 1'b0;
        for (int s = 0; s < 60; s++) begin
            start_btn    = ($urandom_range(0, 3) == 0);
            pause_btn    = ($urandom_range(0, 2) == 0);
            score_in     = 6'($urandom_range(0, 63));
            game_over_in = ($urandom_range(0, 9) == 0) ?
                           6'($urandom_range(1, 63)) : 6'd0;
            cyc($urandom_range(5, 60));
        end
        start_btn    = 1'b0;
        pause_btn    = 1'b0;
        game_over_in = '0;
        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the rock/bullet/blaster datapath. It debounces the start and pause buttons and runs the game-state FSM that drives the shared `game_state` bus. It issues a one-cycle datapath reset at the start of each game, derives the difficulty level from the score, and generates a level-scaled rock step tick. It also keeps the high score and the elapsed play time. It sits between the board buttons and the rock, bullet and blaster blocks, all clocked on the 1 ms clock.

## Interface
Parameters:
- DEBOUNCE_MS, 20, consecutive stable cycles required before a button level is accepted
- LEVEL_STEP, 10, score points per level
- MAX_LEVEL, 7, level saturation value
- BASE_PERIOD, 8, step_tick period in cycles at level 0
- OVER_HOLD_MS, 3000, minimum cycles spent in OVER before a restart is accepted

Ports:
- clk_1ms  in  1  1 ms system clock
- reset  in  1  synchronous, active-low
- start_btn  in  1  raw start button, active-high, asynchronous to clk_1ms
- pause_btn  in  1  raw pause button, active-high, asynchronous to clk_1ms
- game_over_in  in  6  datapath game-over flag; any nonzero value means the game is over
- score_in  in  6  current score from the datapath
- game_state  out  2  00 IDLE, 01 PLAY, 11 PAUSE, 10 OVER
- datapath_reset_n  out  1  active-low reset to the datapath blocks
- level  out  3  current difficulty level
- step_tick  out  1  one-cycle rock step strobe
- high_score  out  6  best score since reset
- play_seconds  out  10  seconds spent in PLAY during the current game

## Operation
- Reset is synchronous and active-low, on clock clk_1ms.
- Reset values: game_state=00, datapath_reset_n=0, level=0, step_tick=0, high_score=0, play_seconds=0. All debounce and divider counters are cleared.
- Synchronizer: each button passes through a 2-flop synchronizer before debounce.
- Debounce: the debounced level changes only after the synchronized input differs from it for DEBOUNCE_MS consecutive cycles. A press is the rising edge of the debounced level, and it produces a single-cycle event.
- FSM transitions:
  - IDLE: start press → PLAY, with a game start. Pause presses are ignored.
  - PLAY: game_over_in≠0 → OVER. Otherwise, a pause press → PAUSE. Game-over has priority over pause in the same cycle. Start presses are ignored.
  - PAUSE: pause press → PLAY. Start presses and game_over_in are ignored.
  - OVER: start press → PLAY with a game start, accepted only when the hold counter has reached OVER_HOLD_MS. Earlier presses are discarded and are not queued.
- Game start, all in the same edge: datapath_reset_n is driven 0 for exactly one cycle, then 1. level, play_seconds, the step divider and the ms prescaler are cleared.
- OVER entry:
  - The hold counter is cleared. It then counts and saturates at OVER_HOLD_MS.
  - If score_in > high_score, high_score takes score_in on the same edge. Equal scores do not update.
  - high_score is cleared only by reset.
- Level: in PLAY only, level is registered as min(score_in / LEVEL_STEP, MAX_LEVEL). It is held in PAUSE and OVER.
- Step divider:
  - Period = max(BASE_PERIOD − level, 1).
  - The counter increments in PLAY only. When counter ≥ period−1, step_tick=1 and the counter returns to 0.
  - The ≥ comparison covers a mid-count period shrink.
  - The counter is held in PAUSE, and step_tick is 0 outside PLAY.
- Play time:
  - The ms prescaler counts 0..999 in PLAY only.
  - On the wrap, play_seconds increments, saturating at 1023.
  - Both are held in PAUSE and OVER.

## Timing
- Button press to state change: 2 synchronizer cycles + DEBOUNCE_MS + 1 registered edge. This is 23 cycles at default parameters.
- game_over_in≠0 sampled in PLAY → game_state=10 on the next edge, one cycle of latency.
- On a game start, game_state=01 and datapath_reset_n=0 are registered on the same edge. datapath_reset_n returns to 1 on the following edge.
- step_tick is registered. At level L it has exactly one high cycle per max(8−L,1) cycles of PLAY.
- Reset asserted mid-game takes effect on the next edge: every output returns to its reset value, high_score included. datapath_reset_n deasserts on the first edge after reset deasserts.
- Button bounces shorter than DEBOUNCE_MS produce no event. Holding a button produces exactly one press.

## Test plan
- Reset, then start_btn held 30 cycles → game_state 00→01 after 23 cycles; datapath_reset_n=0 for exactly 1 cycle; no further transitions while the button is held.
- start_btn toggled every 5 cycles for 100 cycles in IDLE → game_state stays 00 and no press event is produced.
- PLAY with score_in=0 → step_tick once every 8 cycles. score_in=25 → level=2, period 6. score_in=63 → level=6, period 2.
- PLAY for 2500 cycles, pause press, wait 1000 cycles, pause press → play_seconds=2 during PAUSE and step_tick silent; counting resumes after the second press.
- game_over_in=6'h0F and a pause press in the same cycle with score_in=12, high_score=5 → game_state=10, high_score=12. A start press 1000 cycles after OVER entry is ignored; a start press after 3000 cycles → PLAY, level=0, play_seconds=0.
- Reset pulsed low while in PAUSE with high_score=12 → game_state=00, high_score=0, datapath_reset_n=0 during reset and 1 on the next edge after release.
